// File: rtl/clock_ctrl.sv
// -----------------------------------------------------------------------------
// clock_ctrl
// Time-set and run controller for the 24-hour BCD clock datapath.
//   * RUN    : emits a one-cycle `en` pulse every TICK_DIV system clocks and
//              honours `btn_clr` (one-cycle `clr` strobe).
//   * SET_H/SET_M/SET_S : edit a shadow copy of the time captured from the
//              datapath. `btn_mode` steps to the next field and `btn_inc`
//              edits the selected field.
//   * COMMIT : one-cycle `load` strobe, which presets the datapath from the
//              shadow digits.
//
// Ports
//   clk, rst_n                 system clock, async active-low reset
//   btn_mode, btn_inc, btn_clr debounced push-button levels
//   sq0/sq1, mq0/mq1, hq0/hq1  current time digits from the datapath
//   en                         datapath count enable (1 pulse per second)
//   load                       datapath preset strobe
//   clr                        datapath clear strobe
//   sd0/sd1, md0/md1, hd0/hd1  shadow (preset) digits
//   field                      edit indicator: 00 none, 01 h, 10 m, 11 s
// -----------------------------------------------------------------------------
module clock_ctrl #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_clr,
  input  logic [3:0] sq0,
  input  logic [2:0] sq1,
  input  logic [3:0] mq0,
  input  logic [2:0] mq1,
  input  logic [3:0] hq0,
  input  logic [1:0] hq1,
  output logic       en,
  output logic       load,
  output logic       clr,
  output logic [3:0] sd0,
  output logic [2:0] sd1,
  output logic [3:0] md0,
  output logic [2:0] md1,
  output logic [3:0] hd0,
  output logic [2:0] hd1,
  output logic [1:0] field
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_TOP = CW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    RUN,
    SET_H,
    SET_M,
    SET_S,
    COMMIT
  } state_t;

  state_t        state;
  logic [CW-1:0] tick;
  logic          mode_prev, inc_prev, clr_prev;

  // Rising-edge detection with fixed priority clr > mode > inc. A clear press
  // swallows any simultaneous lower-priority press, even where clear itself
  // has no effect (the SET states).
  logic press_clr, press_mode, press_inc;
  logic do_mode, do_inc;

  // Next shadow values for a BCD increment of the selected field.
  logic [2:0] hd1_inc;
  logic [3:0] hd0_inc;
  logic [2:0] md1_inc;
  logic [3:0] md0_inc;

  // NOTE: every always_comb output gets a default first, so no path through
  // the block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    press_clr  = btn_clr  & ~clr_prev;
    press_mode = btn_mode & ~mode_prev;
    press_inc  = btn_inc  & ~inc_prev;
    do_mode    = press_mode & ~press_clr;
    do_inc     = press_inc  & ~press_mode & ~press_clr;

    // Hours: 23 and any invalid value go to 00.
    hd1_inc = '0;
    hd0_inc = '0;
    if (hd0 > 4'd9 || hd1 > 3'd2 || (hd1 == 3'd2 && hd0 >= 4'd3)) begin
      hd1_inc = '0;
      hd0_inc = '0;
    end else if (hd0 == 4'd9) begin
      hd1_inc = hd1 + 3'd1;
    end else begin
      hd1_inc = hd1;
      hd0_inc = hd0 + 4'd1;
    end

    // Minutes: 59 and any invalid value go to 00.
    md1_inc = '0;
    md0_inc = '0;
    if (md0 > 4'd9 || md1 > 3'd5 || (md1 == 3'd5 && md0 == 4'd9)) begin
      md1_inc = '0;
      md0_inc = '0;
    end else if (md0 == 4'd9) begin
      md1_inc = md1 + 3'd1;
    end else begin
      md1_inc = md1;
      md0_inc = md0 + 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      tick      <= '0;
      mode_prev <= 1'b0;
      inc_prev  <= 1'b0;
      clr_prev  <= 1'b0;
      en        <= 1'b0;
      load      <= 1'b0;
      clr       <= 1'b0;
      field     <= 2'b00;
      // NOTE: the shadow registers are a handful of flops, not a memory, and
      // they drive outputs directly, so they are reset like any other state.
      sd0       <= '0;
      sd1       <= '0;
      md0       <= '0;
      md1       <= '0;
      hd0       <= '0;
      hd1       <= '0;
    end else begin
      mode_prev <= btn_mode;
      inc_prev  <= btn_inc;
      clr_prev  <= btn_clr;
      en        <= 1'b0;
      load      <= 1'b0;
      clr       <= 1'b0;

      case (state)
        RUN: begin
          if (press_clr) begin
            clr  <= 1'b1;
            tick <= '0;
          end else if (do_mode) begin
            sd0   <= sq0;
            sd1   <= sq1;
            md0   <= mq0;
            md1   <= mq1;
            hd0   <= hq0;
            hd1   <= {1'b0, hq1};
            tick  <= '0;
            field <= 2'b01;
            state <= SET_H;
          end else if (tick == TICK_TOP) begin
            tick <= '0;
            en   <= 1'b1;
          end else begin
            tick <= tick + CW'(1);
          end
        end

        SET_H: begin
          tick <= '0;
          if (do_mode) begin
            field <= 2'b10;
            state <= SET_M;
          end else if (do_inc) begin
            hd1 <= hd1_inc;
            hd0 <= hd0_inc;
          end
        end

        SET_M: begin
          tick <= '0;
          if (do_mode) begin
            field <= 2'b11;
            state <= SET_S;
          end else if (do_inc) begin
            md1 <= md1_inc;
            md0 <= md0_inc;
          end
        end

        SET_S: begin
          tick <= '0;
          if (do_mode) begin
            field <= 2'b00;
            load  <= 1'b1;
            state <= COMMIT;
          end else if (do_inc) begin
            sd1 <= '0;
            sd0 <= '0;
          end
        end

        COMMIT: begin
          // The COMMIT cycle is cycle 0 of the new second, so the first `en`
          // lands exactly TICK_DIV cycles after `load`.
          tick  <= CW'(1);
          field <= 2'b00;
          state <= RUN;
        end

        default: begin
          tick  <= '0;
          field <= 2'b00;
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: doc/clock_ctrl.md
# clock_ctrl

Time-set and run controller for the 24-hour BCD clock datapath (seconds/minutes/hours counters with `en`, `load`, `clr` and parallel BCD preset inputs). Generates the one-cycle-per-second count enable from the system clock. Runs a button-driven set-mode state machine that edits a shadow copy of the time and commits it with a single `load` pulse. Sits between the debounced push-button inputs and the clock datapath.

## Interface
- `TICK_DIV`, 50_000_000, system clock cycles per one-second `en` pulse (≥ 2)
- `clk` input 1, system clock; all logic on rising edge
- `rst_n` input 1, asynchronous active-low reset
- `btn_mode` input 1, debounced level; press advances the set-mode field
- `btn_inc` input 1, debounced level; press increments the selected field
- `btn_clr` input 1, debounced level; press clears the time, honoured only in RUN
- `sq0`/`sq1` input 4/3, current seconds ones/tens from the datapath
- `mq0`/`mq1` input 4/3, current minutes ones/tens
- `hq0`/`hq1` input 4/2, current hours ones/tens
- `en` output 1, datapath count enable; one-cycle pulse per second in RUN
- `load` output 1, datapath preset strobe; one cycle in COMMIT
- `clr` output 1, datapath clear strobe; one cycle
- `sd0`/`sd1` output 4/3, seconds preset (shadow) digits
- `md0`/`md1` output 4/3, minutes preset digits
- `hd0`/`hd1` output 4/3, hours preset digits
- `field` output 2, edit indicator: 00 none, 01 hour, 10 minute, 11 second

## Operation
- Press: a 0→1 transition between two consecutive samples of a `btn_*` input. There is one registered previous-sample flop per button.
- Priority when several presses occur in the same cycle: `btn_clr` > `btn_mode` > `btn_inc`. Lower-priority presses that cycle are discarded.
- States: RUN, SET_H, SET_M, SET_S, COMMIT.
- RUN: `field`=00. Tick counter counts 0..TICK_DIV-1 and wraps. `en`=1 exactly when counter = TICK_DIV-1.
  - `btn_clr` press → `clr`=1 for one cycle, state stays RUN, tick counter reset to 0.
  - `btn_mode` press → capture `hq*/mq*/sq*` into the shadow registers → SET_H. `hd1` is zero-extended from `hq1`.
  - `btn_inc` ignored.
- SET_H (`field`=01), SET_M (10), SET_S (11): `en`=0, tick counter held at 0.
  - `btn_mode` press: SET_H→SET_M→SET_S→COMMIT.
  - `btn_clr` ignored in all three states.
- `btn_inc` in SET_H, hours BCD increment:
  - 23 → 00.
  - Ones digit 9 → ones 0, tens +1.
  - Otherwise ones +1.
  - Any invalid shadow hour (tens ≥ 2 with ones ≥ 3, tens > 2, or ones > 9) → 00.
- `btn_inc` in SET_M, minutes BCD increment:
  - 59 → 00.
  - Ones 9 → ones 0, tens +1.
  - Invalid value (tens > 5 or ones > 9) → 00.
- `btn_inc` in SET_S: seconds shadow set to 00 (sync-to-zero, not increment).
- COMMIT: `load`=1, `en`=0, `field`=00 for exactly one cycle → RUN. Tick counter restarts from 0, so the first `en` comes TICK_DIV cycles after COMMIT.
- `sd*/md*/hd*` always drive the shadow registers. They are only meaningful while `load`=1.
- `load` and `en` are never high in the same cycle. `clr` and `load` are never high in the same cycle.

## Timing
- All outputs are registered. A press detected at rising edge N produces its state, shadow or strobe change visible after edge N. Strobes (`clr`, `load`) are high for exactly one cycle.
- `en` period in RUN is exactly TICK_DIV cycles, with a duty of one cycle.
- Reset (async assert, sync-released by the system):
  - State RUN; tick counter 0; button history 0.
  - Shadow registers 0.
  - `en`, `load`, `clr`, `field` and all preset outputs 0.
- Reset during any SET state or COMMIT discards the shadow edit; no `load` is issued.
- A button held high produces a single press. A new press needs a return to 0 first.

## Test plan
- Tick: TICK_DIV=4, release reset, stay in RUN → `en` high on cycles 4, 8, 12 after reset; `load`=`clr`=0 throughout.
- Set path: datapath at 22:58:37; press mode → `field`=01 and shadow 22:58:37. Then:
  - inc ×2 → 00.
  - mode, inc ×1 → minutes 59.
  - mode, inc → seconds 00.
  - mode → single-cycle `load` with `hd`=0,0 `md`=9,5 `sd`=0,0, then `field`=00.
- Wrap: in SET_M with 59, inc → 00; in SET_H with 09, inc → 10; with 19, inc → 20.
- Invalid capture: `hq1`=2, `hq0`=7 captured; inc in SET_H → 00.
- Priority and ignore: `btn_clr` and `btn_mode` pressed in the same RUN cycle → `clr` pulse only, state RUN. `btn_clr` in SET_M → no `clr`, shadow unchanged.
- Reset mid-edit: assert `rst_n`=0 in SET_S → all outputs 0 immediately, state RUN, no `load` on release; next `en` after TICK_DIV cycles.
